mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage load/store initiator for the byte-addressed, big-endian 32-bit data memory.
- Converts pipeline load and store requests (byte, halfword, word; signed or unsigned) into aligned word accesses on the data-memory port.
- Performs read-modify-write for sub-word stores.
- Holds the pipeline with busy until the access completes, and flags misaligned or out-of-range accesses without touching memory.

Parameters:
MEM_BYTES, 256, data memory size in bytes; any address with addr+size-1 >= MEM_BYTES is an error.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request strobe; sampled only when busy=0
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
busy  output  1  high while an accepted request is in flight; pipeline stalls
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
err  output  1  valid with resp_valid; misaligned, out-of-range or reserved size
mem_addr  output  32  word-aligned address to data memory
mem_wdata  output  32  write word to data memory
mem_re  output  1  memory read enable
mem_we  output  1  memory write enable
mem_rdata  input  32  read word; combinational, valid in the same cycle as mem_re

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high. After reset, state=IDLE and busy, resp_valid, err, mem_re, mem_we = 0; resp_rdata, mem_addr, mem_wdata = 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - busy=0. If req_valid=1, latch the request at the edge and choose the next state:
  - error → RESP with err=1;
  - load → READ;
  - word store → WRITE;
  - byte or half store → READ.
- Error conditions:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=00;
  - addr+bytes > MEM_BYTES.
  - An erroring access produces no mem_re or mem_we cycle.
- READ:
  - mem_re=1, mem_addr = {addr[31:2],2'b00}.
  - mem_rdata is captured into a word register at the edge.
  - Load → RESP. Sub-word store → WRITE.
- WRITE:
  - mem_we=1 for exactly one cycle, then → RESP.
  - mem_wdata is the captured word with the target lane(s) replaced (word store: req_wdata).
- Big-endian lane map:
  - offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0];
  - half at offset 0 = [31:16], at offset 2 = [15:0].
- RESP:
  - resp_valid=1 for one cycle, with err and resp_rdata valid, then → IDLE.
  - Load data is extracted per the lane map, then extended per req_signed.
- busy = (state != IDLE).
- mem_re and mem_we are never high together. Both are 0 in IDLE and RESP.
- mem_addr and mem_wdata hold their last values outside READ and WRITE.
- Latency from the accepting edge N:
  - load: resp_valid in cycle N+2;
  - word store: resp_valid in cycle N+2;
  - sub-word store: resp_valid in cycle N+3;
  - error: resp_valid in cycle N+1.
- req_valid while busy=1 is ignored; no queueing.
- Back-to-back requests: a new request can be accepted in the cycle after RESP (IDLE).
- Reset mid-operation:
  - The next edge forces IDLE and all outputs to reset values.
  - No resp_valid is produced for the aborted request.
  - A store aborted in READ leaves memory unmodified.

Test Plan:
- Preload word 0x10 = 0x8899AABB. lb 0x11 signed → resp_rdata 0xFFFFFF99, err=0, exactly one mem_re cycle, resp at N+2. lbu 0x11 → 0x00000099.
- Same word: lh 0x12 signed → 0xFFFFAABB. lhu 0x10 → 0x00008899.
- sb 0x13 with wdata 0x000000CC → one mem_re cycle, then one mem_we cycle with mem_wdata 0x8899AACC at mem_addr 0x10; resp at N+3. A following lw 0x10 → 0x8899AACC.
- sw 0x20 = 0x12345678 → one mem_we cycle, no mem_re, resp at N+2. Then lw 0xFC (MEM_BYTES=256) is legal, while lw 0x100, lh 0x11, lw 0x22 and size=11 each give resp at N+1 with err=1, resp_rdata=0, and no memory enable.
- Assert req_valid during busy with a different address → ignored. Exactly one resp per accepted request. Requests issued on consecutive IDLE cycles both complete.
- Assert rst during the WRITE cycle of sb and separately during READ → IDLE next edge, all outputs 0, no resp_valid. The READ-aborted store leaves memory unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store initiator for a big-endian, byte-addressed 32-bit data memory.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [32:0] req_bytes;
  logic        req_err;
  logic [4:0]  lane_sh;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  always_comb begin
    case (req_size)
      2'b00:   req_bytes = 33'd1;
      2'b01:   req_bytes = 33'd2;
      default: req_bytes = 33'd4;
    endcase
    req_err = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
           || (({1'b0, req_addr} + req_bytes) > 33'(MEM_BYTES));
  end

  // Big-endian lane position: byte offset 0 lives in the top byte of the word.
  always_comb begin
    lane_sh   = '0;
    lane_mask = '1;
    lane_data = {16'h0, wdata_q};
    case (size_q)
      2'b00: begin
        lane_sh   = {~off_q, 3'b000};
        lane_mask = 32'h0000_00ff << lane_sh;
        lane_data = {24'h0, wdata_q[7:0]} << lane_sh;
      end
      2'b01: begin
        lane_sh   = {~off_q[1], 4'b0000};
        lane_mask = 32'h0000_ffff << lane_sh;
        lane_data = {16'h0, wdata_q} << lane_sh;
      end
      default: ;
    endcase
    lane_byte = 8'(word_q >> lane_sh);
    lane_half = 16'(word_q >> lane_sh);
    case (size_q)
      2'b00:   load_ext = signed_q ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
      2'b01:   load_ext = signed_q ? {{16{lane_half[15]}}, lane_half} : {16'h0, lane_half};
      default: load_ext = word_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          off_d    = req_addr[1:0];
          wdata_d  = req_wdata[15:0];
          err_d    = req_err;
          // mem_addr/mem_wdata only move when a memory cycle follows, so they hold otherwise.
          if (req_err) begin
            state_d = RESP;
          end else if (req_we && req_size == 2'b10) begin
            state_d     = WRITE;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = READ;
            mem_addr_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      READ: begin
        word_d = mem_rdata;
        if (we_q) begin
          mem_wdata_d = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
          state_d     = WRITE;
        end else begin
          state_d = RESP;
        end
      end
      WRITE: state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      off_q       <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign mem_re     = (state_q == READ);
  assign mem_we     = (state_q == WRITE);
  assign resp_valid = (state_q == RESP);
  assign err        = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_ext : '0;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, resp_valid, err, mem_re, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_access_unit #(.MEM_BYTES(256)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .err(err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory the DUT talks to (word array, combinational read)
  logic [31:0] dmem [64] = '{default: '0};
  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;

  // Reference model: plain byte array, big-endian
  logic [7:0] ref_mem [256] = '{default: '0};

  typedef struct { logic [31:0] rdata; logic err; int unsigned cyc; } resp_t;
  typedef struct { bit is_we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
  resp_t rq[$];
  acc_t  aq[$];

  int checks = 0, failures = 0;
  int timeouts = 0;
  int idle_req = 0, idle_done = 0;
  bit done = 0;

  function automatic logic [31:0] ref_word(input int unsigned a);
    return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
  endfunction

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) timeouts++;
  endtask

  task automatic issue(input bit we, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit junk);
    int n;
    logic [63:0] last;
    bit e;
    logic [31:0] v;
    resp_t r;
    acc_t ac;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last = 64'(a) + 64'(n);
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (last > 64'd256);
    wait_idle();
    v = '0;
    if (!e && !we) begin
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[a[7:0] + 8'(i)]);
      if (sg && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (sg && n == 2) v = {{16{v[15]}}, v[15:0]};
    end
    r.rdata = v;
    r.err = e;
    r.cyc = cyc + (e ? 1 : (!we ? 2 : (sz == 2'd2 ? 2 : 3)));
    rq.push_back(r);
    if (!e) begin
      if (!we || sz != 2'd2) begin
        ac.is_we = 0; ac.addr = {a[31:2], 2'b00}; ac.wdata = '0;
        aq.push_back(ac);
      end
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[a[7:0] + 8'(i)] = 8'(wd >> (8 * (n - 1 - i)));
        ac.is_we = 1; ac.addr = {a[31:2], 2'b00}; ac.wdata = ref_word({24'h0, a[7:2], 2'b00});
        aq.push_back(ac);
      end
    end
    req_valid = 1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    if (junk) begin
      req_we = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
      req_addr = a ^ 32'h0000_0044; req_wdata = $urandom;
      @(posedge clk);
      #1;
    end
    req_valid = 0;
  endtask

  task automatic abort_store(input logic [31:0] a, input logic [7:0] b, input bit in_write);
    acc_t ac;
    wait_idle();
    ac.is_we = 0; ac.addr = {a[31:2], 2'b00}; ac.wdata = '0;
    aq.push_back(ac);
    if (in_write) begin
      ref_mem[a[7:0]] = b;
      ac.is_we = 1; ac.wdata = ref_word({24'h0, a[7:2], 2'b00});
      aq.push_back(ac);
    end
    req_valid = 1; req_we = 1; req_size = 2'd0; req_signed = 0; req_addr = a; req_wdata = {24'h0, b};
    @(posedge clk);
    #1 req_valid = 0;
    if (in_write) begin
      @(posedge clk);
      #1;
    end
    rst = 1;
    @(posedge clk);
    #1 idle_req++;
    @(negedge clk);
    #1 rst = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    resp_t r;
    acc_t ac;
    forever begin
      @(negedge clk);
      if (idle_req != idle_done) begin
        idle_done++;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
      end
      if (mem_re || mem_we) begin
        chk("re_we_exclusive", 32'(mem_re && mem_we), 0);
        if (aq.size() == 0) begin
          chk("unexpected_mem_access", 32'(1), 0);
        end else begin
          ac = aq.pop_front();
          chk("access_is_write", 32'(mem_we), 32'(ac.is_we));
          chk("mem_addr", mem_addr, ac.addr);
          if (ac.is_we) chk("mem_wdata", mem_wdata, ac.wdata);
        end
      end
      if (resp_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_resp", 32'(1), 0);
        end else begin
          r = rq.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", 32'(err), 32'(r.err));
          chk("resp_cycle", cyc, r.cyc);
        end
      end
      if (done) begin
        chk("pending_resps", 32'(rq.size()), 0);
        chk("pending_accesses", 32'(aq.size()), 0);
        chk("wait_timeouts", 32'(timeouts), 0);
        for (int unsigned i = 0; i < 64; i++) chk($sformatf("mem_word_%0d", i), dmem[i], ref_word(i * 4));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    logic [31:0] a;
    logic [1:0] sz;
    int sel;
    repeat (3) @(posedge clk);
    #1 idle_req++;
    @(negedge clk);
    #1 rst = 0;

    issue(1, 2'd2, 0, 32'h10, 32'h8899AABB, 0);
    issue(0, 2'd0, 1, 32'h11, 32'h0, 0);
    issue(0, 2'd0, 0, 32'h11, 32'h0, 0);
    issue(0, 2'd1, 1, 32'h12, 32'h0, 0);
    issue(0, 2'd1, 0, 32'h10, 32'h0, 0);
    issue(1, 2'd0, 0, 32'h13, 32'h000000CC, 0);
    issue(0, 2'd2, 0, 32'h10, 32'h0, 0);
    issue(1, 2'd2, 0, 32'h20, 32'h12345678, 0);
    issue(0, 2'd2, 0, 32'hFC, 32'h0, 0);
    issue(0, 2'd2, 0, 32'h100, 32'h0, 0);
    issue(0, 2'd1, 1, 32'h11, 32'h0, 0);
    issue(0, 2'd2, 0, 32'h22, 32'h0, 0);
    issue(0, 2'd3, 0, 32'h0, 32'h0, 0);
    issue(1, 2'd0, 0, 32'hFFFF_FFFF, 32'h11, 0);
    issue(0, 2'd2, 0, 32'h20, 32'h0, 1);
    issue(1, 2'd1, 0, 32'h32, 32'h0000BEEF, 1);
    issue(0, 2'd1, 0, 32'hFE, 32'h0, 1);

    abort_store(32'h21, 8'h55, 0);
    abort_store(32'h22, 8'h66, 1);
    issue(0, 2'd2, 0, 32'h20, 32'h0, 0);

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 7);
      sz = (sel < 2) ? 2'd0 : (sel < 4) ? 2'd1 : (sel < 7) ? 2'd2 : 2'd3;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 263));
      if ($urandom_range(0, 4) != 0) a = a & ~(32'(n) - 1);
      issue($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, a, $urandom,
            $urandom_range(0, 3) == 0);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    done = 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
